// File: rtl/instruction_loader_pkg.sv
// instruction_loader_pkg: shared FSM encoding and word-shape constants for the instruction loader.
package instruction_loader_pkg;
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/instruction_loader_word_assembler.sv
// word_assembler: packs accepted bytes little-endian into a 32-bit word and flags the last byte.
module word_assembler
    import instruction_loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        en,
    input  logic [7:0]                  byte_data,
    output logic [8*BYTES_PER_WORD-1:0] word,
    output logic                        word_last
);
    localparam int CW = $clog2(BYTES_PER_WORD);
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [8*BYTES_PER_WORD-1:0] word_q, word_d;
    always_comb begin
        cnt_d  = clr ? '0 : (en ? cnt_q + CW'(1) : cnt_q);
        word_d = word_q;
        if (en && !clr) word_d[8*cnt_q +: 8] = byte_data;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end
    assign word      = word_q;
    assign word_last = en && !clr && cnt_q == CW'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: receives a byte stream and writes assembled 32-bit words to an instruction memory.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              error
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, len_q, len_d;
    logic              error_q, error_d;
    logic              clr, word_last, len_ok;
    assign len_ok = load_len != '0 && load_len <= ADDR_W'(DEPTH);
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        error_d = error_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = len_ok ? RECV : DONE;
                error_d = !len_ok;
                if (len_ok) begin
                    addr_d = '0;
                    len_d  = load_len;
                    clr    = 1'b1;
                end
            end
            RECV:  state_d = word_last ? WRITE : RECV;
            WRITE: begin
                state_d = addr_q == len_q - ADDR_W'(1) ? DONE : RECV;
                addr_d  = addr_q == len_q - ADDR_W'(1) ? addr_q : addr_q + ADDR_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            error_q <= error_d;
        end
    end
    word_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .en        (byte_valid && byte_ready),
        .byte_data (byte_data),
        .word      (wr_data),
        .word_last (word_last)
    );
    // All strobes decode straight from the state register, so they are glitch-free and reset to 0.
    assign byte_ready = state_q == RECV;
    assign wr_en      = state_q == WRITE;
    assign busy       = state_q == RECV || state_q == WRITE;
    assign done       = state_q == DONE;
    assign wr_addr    = addr_q;
    assign error      = error_q;
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed tests with a write scoreboard for instruction_loader.
module tb_instruction_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] load_len = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, wr_en, busy, done, error;
    logic [31:0] wr_addr, wr_data;
    int compared = 0;
    int mismatched = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [31:0] last_addr = '0;
    logic [63:0] exp_q[$];
    instruction_loader #(.DEPTH(32), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .load_len   (load_len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // Scoreboard: every write strobe pops the next expected {addr, data}.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (wr_en === 1'b1) begin
            logic [63:0] e;
            wr_cnt++;
            last_addr = wr_addr;
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            e = exp_q.size() != 0 ? exp_q.pop_front() : '0;
            check("write_addr_data", {wr_addr, wr_data}, e);
            check("ready_low_in_write", 64'(byte_ready), 64'd0);
        end
    end
    task automatic start_load(input logic [31:0] len);
        start = 1'b1;
        load_len = len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        byte_valid = 1'b0;
        repeat (gap) @(posedge clk);
        if (gap != 0) #1;
        byte_valid = 1'b1;
        byte_data = b;
        @(negedge clk);
        while (byte_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("byte_ready_timeout", 64'(t), 64'd0);
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask
    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], max_gap == 0 ? 0 : int'($urandom_range(0, max_gap)));
    endtask
    task automatic wait_done();
        int t = 0;
        @(negedge clk);
        while (done !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", 64'(t < 200), 64'd1);
        @(posedge clk); #1;
    endtask
    initial begin
        int w0, d0;
        logic [31:0] words [3];
        #3;
        check("reset_outputs", {byte_ready, wr_en, busy, done, error, wr_addr}, '0);
        check("reset_wr_data", 64'(wr_data), 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        // Test 1: single word, back-to-back bytes, latency check.
        exp_q.push_back({32'd0, 32'h12345678});
        start_load(32'd1);
        check("busy_after_start", 64'(busy), 64'd1);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        @(negedge clk);
        check("t1_wr_en_latency", 64'(wr_en), 64'd1);
        @(negedge clk);
        check("t1_done_after_write", 64'(done), 64'd1);
        @(negedge clk);
        check("t1_done_one_cycle", 64'(done), 64'd0);
        check("t1_write_count", 64'(wr_cnt), 64'd1);
        @(posedge clk); #1;
        // Test 2: three words with random gaps.
        words = '{32'hDEADBEEF, 32'h00C0FFEE, 32'hA5A55A5A};
        for (int i = 0; i < 3; i++) exp_q.push_back({32'(i), words[i]});
        start_load(32'd3);
        for (int i = 0; i < 3; i++) send_word(words[i], 3);
        wait_done();
        check("t2_write_count", 64'(wr_cnt), 64'd4);
        // Test 3: rejected lengths and error clearing.
        w0 = wr_cnt;
        d0 = done_cnt;
        start_load(32'd0);
        @(negedge clk);
        check("t3_len0_done", 64'(done), 64'd1);
        check("t3_len0_error", 64'(error), 64'd1);
        @(posedge clk); #1;
        start_load(32'd33);
        @(negedge clk);
        check("t3_len33_done", 64'(done), 64'd1);
        @(negedge clk);
        check("t3_error_sticky", 64'(error), 64'd1);
        check("t3_no_writes", 64'(wr_cnt - w0), 64'd0);
        check("t3_done_pulses", 64'(done_cnt - d0), 64'd2);
        @(posedge clk); #1;
        exp_q.push_back({32'd0, 32'h01020304});
        start_load(32'd1);
        check("t3_error_cleared", 64'(error), 64'd0);
        send_word(32'h01020304, 0);
        wait_done();
        // Test 4: full depth.
        w0 = wr_cnt;
        for (int i = 0; i < 32; i++) exp_q.push_back({32'(i), 32'h1000_0000 + 32'(i * 7)});
        start_load(32'd32);
        for (int i = 0; i < 32; i++) send_word(32'h1000_0000 + 32'(i * 7), 0);
        wait_done();
        check("t4_write_count", 64'(wr_cnt - w0), 64'd32);
        check("t4_last_addr", 64'(last_addr), 64'd31);
        // Test 5: asynchronous reset mid-word.
        exp_q.push_back({32'd0, 32'hCAFEBABE});
        start_load(32'd3);
        send_word(32'hCAFEBABE, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        w0 = wr_cnt;
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("t5_async_outputs", {byte_ready, wr_en, busy, done, error, wr_addr}, '0);
        check("t5_async_wr_data", 64'(wr_data), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_write_after_reset", 64'(wr_cnt - w0), 64'd0);
        check("t5_no_done_after_reset", 64'(done_cnt - d0), 64'd0);
        exp_q.push_back({32'd0, 32'h55667788});
        start_load(32'd1);
        send_word(32'h55667788, 1);
        wait_done();
        // Test 6: start during RECV is ignored.
        w0 = wr_cnt;
        exp_q.push_back({32'd0, 32'h0BADF00D});
        exp_q.push_back({32'd1, 32'h76543210});
        start_load(32'd2);
        send_byte(8'h0D, 0);
        start_load(32'd5);
        send_byte(8'hF0, 0);
        send_byte(8'hAD, 0);
        send_byte(8'h0B, 0);
        send_word(32'h76543210, 0);
        wait_done();
        check("t6_write_count", 64'(wr_cnt - w0), 64'd2);
        repeat (10) @(posedge clk);
        #1;
        check("t6_idle_no_busy", 64'(busy), 64'd0);
        check("t6_no_extra_writes", 64'(wr_cnt - w0), 64'd2);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
